// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and the MEM stage,
// with a fixed-latency response tag pipe, a DM starvation limit and squash of in-flight fetches.
module mem_port_arbiter #(
  parameter int AW            = 14,
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IF_REQ,
  input  logic [AW-1:0] IF_ADDR,
  output logic          IF_GNT,
  output logic          IF_RVALID,
  output logic [31:0]   IF_RDATA,
  input  logic          FLUSH,
  input  logic          DM_REQ,
  input  logic          DM_WE,
  input  logic [3:0]    DM_BE,
  input  logic [AW-1:0] DM_ADDR,
  input  logic [31:0]   DM_WDATA,
  output logic          DM_GNT,
  output logic          DM_RVALID,
  output logic [31:0]   DM_RDATA,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [3:0]    MEM_BE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [31:0]   MEM_WDATA,
  input  logic [31:0]   MEM_RDATA
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  logic [SW-1:0]      streak_r;
  logic [MEM_LAT-1:0] tag_vld_r;
  logic [MEM_LAT-1:0] tag_if_r;
  logic               streak_max_s;
  logic               dm_sel_s;
  logic               if_sel_s;
  logic               rsp_vld_s;
  logic               rsp_if_s;

  // Grant selection and memory-side request mux; DM wins unless IF has waited out the streak
  always_comb begin
    streak_max_s = (streak_r == SW'(MAX_DM_STREAK));
    dm_sel_s     = DM_REQ & ~(IF_REQ & streak_max_s);
    if_sel_s     = IF_REQ & ~dm_sel_s;
    IF_GNT       = 1'b0;
    DM_GNT       = 1'b0;
    MEM_EN       = 1'b0;
    MEM_WE       = 1'b0;
    MEM_BE       = 4'b0000;
    MEM_ADDR     = {AW{1'b0}};
    MEM_WDATA    = 32'h0000_0000;
    if (RST) begin
      MEM_EN = 1'b0;
    end else if (dm_sel_s) begin
      DM_GNT    = 1'b1;
      MEM_EN    = 1'b1;
      MEM_WE    = DM_WE;
      MEM_BE    = DM_BE;
      MEM_ADDR  = DM_ADDR;
      MEM_WDATA = DM_WDATA;
    end else if (if_sel_s) begin
      IF_GNT   = 1'b1;
      MEM_EN   = 1'b1;
      MEM_ADDR = IF_ADDR;
    end else begin
      MEM_EN = 1'b0;
    end
  end

  // Route the returning read word to its owner; a redirect hides fetch data immediately
  always_comb begin
    rsp_vld_s = tag_vld_r[MEM_LAT-1] & ~RST;
    rsp_if_s  = tag_if_r[MEM_LAT-1];
    IF_RVALID = rsp_vld_s & rsp_if_s & ~FLUSH;
    DM_RVALID = rsp_vld_s & ~rsp_if_s;
    IF_RDATA  = MEM_RDATA & {32{IF_RVALID}};
    DM_RDATA  = MEM_RDATA & {32{DM_RVALID}};
  end

  // Tag pipe: flush kills fetch tags already in flight, but the fetch granted now is kept
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_vld_r <= {MEM_LAT{1'b0}};
      tag_if_r  <= {MEM_LAT{1'b0}};
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        tag_vld_r[i] <= tag_vld_r[i-1] & ~(FLUSH & tag_if_r[i-1]);
        tag_if_r[i]  <= tag_if_r[i-1];
      end
      tag_vld_r[0] <= MEM_EN & ~MEM_WE;
      tag_if_r[0]  <= IF_GNT;
    end
  end

  // Count DM grants taken while a fetch is waiting
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_r <= {SW{1'b0}};
    end else if (IF_GNT | ~IF_REQ) begin
      streak_r <= {SW{1'b0}};
    end else if (DM_GNT & ~streak_max_s) begin
      streak_r <= streak_r + SW'(1);
    end else begin
      streak_r <= streak_r;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (MEM_LAT=2): directed vector table, hand sequences for flush/reset,
// then constrained-random traffic against a queue-based reference model of the memory port.
module tb_mem_port_arbiter;

  localparam int AW   = 14;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IF_REQ, IF_GNT, IF_RVALID, FLUSH;
  logic [AW-1:0] IF_ADDR;
  logic [31:0]   IF_RDATA;
  logic          DM_REQ, DM_WE, DM_GNT, DM_RVALID;
  logic [3:0]    DM_BE;
  logic [AW-1:0] DM_ADDR;
  logic [31:0]   DM_WDATA, DM_RDATA;
  logic          MEM_EN, MEM_WE;
  logic [3:0]    MEM_BE;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_WDATA, MEM_RDATA;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT), .MAX_DM_STREAK(MAXS)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
    .FLUSH(FLUSH),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_BE(DM_BE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_GNT(DM_GNT), .DM_RVALID(DM_RVALID), .DM_RDATA(DM_RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA)
  );

  function automatic logic [31:0] iv(input logic [AW-1:0] a);
    return (a == AW'(5)) ? 32'h0000_0000 : (32'hC0DE_0000 | 32'(a));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory macro environment: byte-masked writes, reads return LAT cycles later, junk otherwise
  logic [31:0] phys_mem [0:(1<<AW)-1];
  logic [31:0] rd_pipe  [0:LAT-1];
  logic [31:0] rd_new;
  assign MEM_RDATA = rd_pipe[LAT-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) phys_mem[i] = iv(AW'(i));
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'h0;
    forever begin
      @(posedge CLK);
      rd_new = (MEM_EN && !MEM_WE) ? phys_mem[MEM_ADDR] : $urandom;
      if (MEM_EN && MEM_WE)
        for (int b = 0; b < 4; b++)
          if (MEM_BE[b]) phys_mem[MEM_ADDR][8*b +: 8] = MEM_WDATA[8*b +: 8];
      for (int i = LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      rd_pipe[0] = rd_new;
    end
  end

  // Reference model: streak count, reference memory and a queue of responses due at cycle numbers
  typedef struct { int due; bit is_if; logic [31:0] data; } rsp_t;
  rsp_t        rq[$];
  int          streak = 0;
  int          cyc = 0;
  logic [31:0] ref_mem [0:(1<<AW)-1];

  function automatic bit mdl_dm_gnt();
    return !RST && DM_REQ && !(IF_REQ && streak == MAXS);
  endfunction
  function automatic bit mdl_if_gnt();
    return !RST && IF_REQ && !mdl_dm_gnt();
  endfunction

  initial begin
    bit eif, edm;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = iv(AW'(i));
    forever begin
      @(posedge CLK);
      eif = mdl_if_gnt();
      edm = mdl_dm_gnt();
      if (RST) begin
        rq.delete();
        streak = 0;
      end else begin
        for (int i = rq.size() - 1; i >= 0; i--)
          if (rq[i].due <= cyc || (FLUSH && rq[i].is_if)) rq.delete(i);
        if (edm && DM_WE)
          for (int b = 0; b < 4; b++)
            if (DM_BE[b]) ref_mem[DM_ADDR][8*b +: 8] = DM_WDATA[8*b +: 8];
        if (eif) rq.push_back('{cyc + LAT, 1'b1, ref_mem[IF_ADDR]});
        else if (edm && !DM_WE) rq.push_back('{cyc + LAT, 1'b0, ref_mem[DM_ADDR]});
        if (eif || !IF_REQ) streak = 0;
        else if (edm && streak < MAXS) streak = streak + 1;
      end
      cyc++;
    end
  end

  // Mid-cycle comparison of every DUT output against the model
  initial begin
    bit eif, edm, fif, fdm;
    logic [31:0] dif, ddm;
    logic [63:0] ebus;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        eif = mdl_if_gnt();
        edm = mdl_dm_gnt();
        fif = 1'b0; fdm = 1'b0; dif = 32'h0; ddm = 32'h0;
        foreach (rq[i])
          if (rq[i].due == cyc) begin
            if (rq[i].is_if) begin fif = 1'b1; dif = rq[i].data; end
            else begin fdm = 1'b1; ddm = rq[i].data; end
          end
        if (RST || FLUSH) begin fif = 1'b0; dif = 32'h0; end
        if (RST) begin fdm = 1'b0; ddm = 32'h0; end
        if (edm) ebus = 64'({1'b1, DM_WE, DM_BE, DM_ADDR, DM_WDATA});
        else if (eif) ebus = 64'({1'b1, 1'b0, 4'h0, IF_ADDR, 32'h0});
        else ebus = 64'h0;
        chk($sformatf("mon_gnt@%0d", cyc), 64'({IF_GNT, DM_GNT}), 64'({eif, edm}));
        chk($sformatf("mon_bus@%0d", cyc), 64'({MEM_EN, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA}), ebus);
        chk($sformatf("mon_if_rsp@%0d", cyc), 64'({IF_RVALID, IF_RDATA}), 64'({fif, dif}));
        chk($sformatf("mon_dm_rsp@%0d", cyc), 64'({DM_RVALID, DM_RDATA}), 64'({fdm, ddm}));
      end
    end
  end

  task automatic drive(input bit ifr, input logic [AW-1:0] ifa, input bit dmr, input bit we,
                       input logic [AW-1:0] dma, input logic [3:0] be, input logic [31:0] wd,
                       input bit fl, input bit rs);
    @(posedge CLK);
    #1;
    IF_REQ = ifr; IF_ADDR = ifa; DM_REQ = dmr; DM_WE = we; DM_ADDR = dma;
    DM_BE = be; DM_WDATA = wd; FLUSH = fl; RST = rs;
  endtask

  task automatic idle(input bit fl);
    drive(1'b0, AW'(0), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, fl, 1'b0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({IF_GNT, DM_GNT, IF_RVALID, DM_RVALID, MEM_EN, MEM_WE, MEM_BE,
                IF_RDATA | DM_RDATA | MEM_WDATA, MEM_ADDR});
  endfunction

  typedef struct {
    bit ifr; logic [AW-1:0] ifa; bit dmr; bit we; logic [AW-1:0] dma; logic [3:0] be; logic [31:0] wd;
    bit eif; bit edm; bit eifrv; logic [31:0] eifrd; bit edmrv; logic [31:0] edmrd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit ifr, input logic [AW-1:0] ifa, input bit dmr, input bit we,
                              input logic [AW-1:0] dma, input logic [3:0] be, input logic [31:0] wd,
                              input bit eif, input bit edm, input bit eifrv, input logic [31:0] eifrd,
                              input bit edmrv, input logic [31:0] edmrd);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.we = we; v.dma = dma; v.be = be; v.wd = wd;
    v.eif = eif; v.edm = edm; v.eifrv = eifrv; v.eifrd = eifrd; v.edmrv = edmrv; v.edmrd = edmrd;
    return v;
  endfunction

  initial begin
    bit gi, gd, nifr, ndmr, nwe, nfl, nrs;
    logic [AW-1:0] nifa, ndma;
    logic [3:0] nbe;
    logic [31:0] nwd;

    // Responses arrive LAT=2 vectors after the read grant
    tbl.push_back(mk(1'b1, AW'('h10), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, AW'('h11), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, AW'('h12), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, iv(AW'('h10)), 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, AW'('h13), 1'b1, 1'b0, AW'('h20), 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, iv(AW'('h11)), 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, AW'('h13), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, iv(AW'('h12)), 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, AW'(0), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, iv(AW'('h20))));
    tbl.push_back(mk(1'b0, AW'(0), 1'b1, 1'b1, AW'(5), 4'b0011, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, iv(AW'('h13)), 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, AW'(0), 1'b1, 1'b0, AW'(5), 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, AW'(0), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, AW'('h14), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_BEEF));
    tbl.push_back(mk(1'b1, AW'('h14), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, AW'('h14), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, iv(AW'('h21))));
    tbl.push_back(mk(1'b1, AW'('h14), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, iv(AW'('h21))));
    tbl.push_back(mk(1'b1, AW'('h14), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, iv(AW'('h21))));
    tbl.push_back(mk(1'b1, AW'('h15), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, iv(AW'('h21))));
    tbl.push_back(mk(1'b1, AW'('h15), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, iv(AW'('h14)), 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, AW'('h15), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, iv(AW'('h21))));
    tbl.push_back(mk(1'b1, AW'('h15), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, iv(AW'('h21))));
    tbl.push_back(mk(1'b1, AW'('h15), 1'b1, 1'b0, AW'('h21), 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, iv(AW'('h21))));
    tbl.push_back(mk(1'b0, AW'(0), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, iv(AW'('h21))));
    tbl.push_back(mk(1'b0, AW'(0), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, iv(AW'('h15)), 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, AW'(0), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));

    RST = 1'b1; FLUSH = 1'b0; IF_REQ = 1'b0; IF_ADDR = AW'(0); DM_REQ = 1'b0; DM_WE = 1'b0;
    DM_BE = 4'h0; DM_ADDR = AW'(0); DM_WDATA = 32'h0;
    @(posedge CLK);
    mon_en = 1'b1;
    @(negedge CLK);
    chk("reset_outs", all_outs(), 64'h0);

    foreach (tbl[k]) begin
      drive(tbl[k].ifr, tbl[k].ifa, tbl[k].dmr, tbl[k].we, tbl[k].dma, tbl[k].be, tbl[k].wd, 1'b0, 1'b0);
      @(negedge CLK);
      chk($sformatf("tbl%0d_gnt", k), 64'({IF_GNT, DM_GNT}), 64'({tbl[k].eif, tbl[k].edm}));
      chk($sformatf("tbl%0d_if_rsp", k), 64'({IF_RVALID, IF_RDATA}), 64'({tbl[k].eifrv, tbl[k].eifrd}));
      chk($sformatf("tbl%0d_dm_rsp", k), 64'({DM_RVALID, DM_RDATA}), 64'({tbl[k].edmrv, tbl[k].edmrd}));
    end

    // Flush squashes the older fetch but keeps the redirected one granted in the flush cycle
    drive(1'b1, AW'('h30), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); chk("flush_g30", 64'(IF_GNT), 64'h1);
    drive(1'b1, AW'('h40), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b1, 1'b0);
    @(negedge CLK); chk("flush_g40", 64'({IF_GNT, IF_RVALID}), 64'h2);
    idle(1'b0);
    @(negedge CLK); chk("flush_squash30", 64'({IF_RVALID, IF_RDATA}), 64'h0);
    idle(1'b0);
    @(negedge CLK); chk("flush_keep40", 64'({IF_RVALID, IF_RDATA}), 64'({1'b1, iv(AW'('h40))}));
    drive(1'b1, AW'('h31), 1'b0, 1'b0, AW'(0), 4'h0, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    idle(1'b0);
    @(negedge CLK);
    idle(1'b1);
    @(negedge CLK); chk("flush_gate_now", 64'({IF_RVALID, IF_RDATA}), 64'h0);
    idle(1'b0);
    @(negedge CLK); chk("flush_gate_after", 64'(IF_RVALID), 64'h0);

    // Reset with a DM read in flight and the streak at its limit
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'('h16), 1'b1, 1'b0, AW'('h22), 4'hF, 32'h0, 1'b0, 1'b0);
      @(negedge CLK); chk($sformatf("rst_pre_dm%0d", i), 64'({IF_GNT, DM_GNT}), 64'h1);
    end
    drive(1'b1, AW'('h16), 1'b1, 1'b0, AW'('h22), 4'hF, 32'h0, 1'b1, 1'b1);
    @(negedge CLK); chk("rst_outs_zero", all_outs(), 64'h0);
    drive(1'b1, AW'('h16), 1'b1, 1'b0, AW'('h22), 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("rst_streak_dm_first", 64'({IF_GNT, DM_GNT}), 64'h1);
    chk("rst_no_stale_rv", 64'(DM_RVALID), 64'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'('h16), 1'b1, 1'b0, AW'('h22), 4'hF, 32'h0, 1'b0, 1'b0);
      @(negedge CLK); chk($sformatf("rst_post_dm%0d", i), 64'({IF_GNT, DM_GNT}), 64'h1);
      if (i == 0) chk("rst_no_stale_rv2", 64'(DM_RVALID), 64'h0);
    end
    drive(1'b1, AW'('h16), 1'b1, 1'b0, AW'('h22), 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge CLK); chk("rst_if_fifth", 64'({IF_GNT, DM_GNT}), 64'h2);
    gi = mdl_if_gnt(); gd = mdl_dm_gnt();

    // Random traffic; a request not yet granted is held unchanged
    nifr = IF_REQ; nifa = IF_ADDR; ndmr = DM_REQ; nwe = DM_WE; ndma = DM_ADDR; nbe = DM_BE; nwd = DM_WDATA;
    for (int n = 0; n < 600; n++) begin
      if (!(nifr && !gi)) begin
        nifr = ($urandom_range(0, 2) != 0);
        nifa = AW'($urandom_range(0, 15));
      end
      if (!(ndmr && !gd)) begin
        ndmr = ($urandom_range(0, 2) != 0);
        nwe  = ($urandom_range(0, 1) != 0);
        ndma = AW'($urandom_range(0, 15));
        nbe  = 4'($urandom_range(0, 15));
        nwd  = $urandom;
      end
      nfl = ($urandom_range(0, 7) == 0);
      nrs = ($urandom_range(0, 59) == 0);
      drive(nifr, nifa, ndmr, nwe, ndma, nbe, nwd, nfl, nrs);
      @(negedge CLK);
      gi = mdl_if_gnt(); gd = mdl_dm_gnt();
    end
    for (int n = 0; n < 5; n++) begin
      idle(1'b0);
      @(negedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
